march_test_engine: RTL

- Built-in self-test sequencer that sits directly upstream of the memory array under test in the mem_test top level.
- Runs a March C- algorithm over every address of a single-port memory and compares each read against the expected background.
- Reports pass/fail, the first failing address and data, and a saturating error count to the top-level output mux.
- The top level drives start/pattern from ui_in and presents the results on uo_out/uio_out.

---
 rtl/march_test_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/march_test_engine.sv
// March C- built-in self-test sequencer for a single-port memory with 1-cycle read latency.
// Issues one read or write per cycle, then checks each read against its expected background.
module march_test_engine #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [2:0]        elem_q;
  logic [ADDR_W-1:0] addr_q;
  logic              phase_q;
  logic [DATA_W-1:0] pat_q;

  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] rd_addr_p1;

  logic accept, elem_dual, elem_down, read_bg, write_bg, step_last, at_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] bg_value(input logic [DATA_W-1:0] p, input logic one);
    return one ? ~p : p;
  endfunction

  assign elem_dual = (elem_q >= 3'd1) && (elem_q <= 3'd4);
  assign elem_down = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign read_bg   = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign write_bg  = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign step_last = !elem_dual || phase_q;
  assign at_end    = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (step_last && at_end && (elem_q == 3'd5)) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // p0: memory operation decoded from the sequencer position
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state_q == RUN) begin
      mem_addr = addr_q;
      if (elem_q == 3'd0) begin
        mem_we    = 1'b1;
        mem_wdata = bg_value(pat_q, 1'b0);
      end else if (elem_q == 3'd5 || !phase_q) begin
        mem_re = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_wdata = bg_value(pat_q, write_bg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      pat_q   <= '0;
    end else if (accept) begin
      pat_q   <= pattern;
      elem_q  <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else if (state_q == RUN) begin
      if (!step_last) begin
        phase_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
        if (at_end) begin
          if (elem_q != 3'd5) begin
            elem_q <= elem_q + 3'd1;
            // e3 and e4 walk downward, so they begin at the top address
            addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
          end
        end else begin
          addr_q <= elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
      end
    end
  end

  // p1: read data returns; compare against the background captured at issue
  always_ff @(posedge clk) begin
    exp_p1     <= bg_value(pat_q, read_bg);
    rd_addr_p1 <= mem_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      vld_p1 <= mem_re;
      if (accept) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        err_count <= '0;
      end else if (vld_p1 && (mem_rdata != exp_p1)) begin
        err_count <= sat_inc(err_count);
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= rd_addr_p1;
          fail_data <= mem_rdata;
        end
      end
    end
  end

endmodule
